// File: rtl/spi_resp_pkg.sv
// Shared types and widths for the dual-I/O SPI read responder.
package spi_resp_pkg;

    localparam int unsigned ADDR_W         = 24;
    localparam int unsigned WADDR_W        = 22;
    localparam int unsigned DATA_W         = 32;
    localparam int unsigned ADDR_PAIRS     = ADDR_W / 2;
    localparam logic [7:0]  CMD_DEFAULT    = 8'hBB;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_IGNORE
    } state_e;

    // Pair idx of a word: byte idx/4 (LSB byte first), bits MSB-first within the byte.
    function automatic logic [1:0] pair_sel(input logic [DATA_W-1:0] w, input logic [3:0] idx);
        logic [7:0] b;
        b = w[{idx[3:2], 3'b000} +: 8];
        case (idx[1:0])
            2'd0:    return b[7:6];
            2'd1:    return b[5:4];
            2'd2:    return b[3:2];
            default: return b[1:0];
        endcase
    endfunction

endpackage

// File: rtl/spi_sck_sync.sv
// Two-flop synchronizers for SCK, CSn and IO pads plus SCK/CS edge detection.
module spi_sck_sync (
    input  logic       clk_i,
    input  logic       resetq_i,
    input  logic       sck_i,
    input  logic       csn_i,
    input  logic [1:0] io_i,
    output logic [1:0] io_o,
    output logic       sck_rise_o,
    output logic       sck_fall_o,
    output logic       cs_fall_o,
    output logic       cs_rise_o
);

    // [0] metastable stage, [1] synchronized, [2] previous synchronized value
    logic [2:0] sck_q;
    logic [2:0] csn_q;
    logic [1:0] io_meta_q;
    logic [1:0] io_q;

    always_ff @(posedge clk_i or negedge resetq_i) begin
        if (!resetq_i) begin
            sck_q     <= '0;
            csn_q     <= '1;
            io_meta_q <= '0;
            io_q      <= '0;
        end else begin
            sck_q     <= {sck_q[1:0], sck_i};
            csn_q     <= {csn_q[1:0], csn_i};
            io_meta_q <= io_i;
            io_q      <= io_meta_q;
        end
    end

    assign io_o       = io_q;
    assign sck_rise_o =  sck_q[1] & ~sck_q[2] & ~csn_q[1];
    assign sck_fall_o = ~sck_q[1] &  sck_q[2] & ~csn_q[1];
    assign cs_fall_o  =  csn_q[2] & ~csn_q[1];
    assign cs_rise_o  = ~csn_q[2] &  csn_q[1];

endmodule

// File: rtl/spi_dual_responder.sv
// Dual-I/O (opcode BBh) SPI read responder fetching 32-bit words from memory.
// Define SPI_RESP_BURST_EN to stream consecutive words while CS stays low.
module spi_dual_responder
    import spi_resp_pkg::*;
#(
    parameter int unsigned DUMMY_CYCLES  = 4,
    parameter logic [7:0]  CMD_DUAL_READ = CMD_DEFAULT
) (
    input  logic               clk,
    input  logic               resetq,
    input  logic               spi_sck,
    input  logic               spi_csn,
    input  logic [1:0]         spi_io_in,
    output logic [1:0]         spi_io_out,
    output logic [1:0]         spi_io_oe,
    output logic               mem_rstrb,
    output logic [WADDR_W-1:0] mem_word_address,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_rbusy,
    output logic               underrun
);

    logic [1:0] io_s;
    logic       sck_rise;
    logic       sck_fall;
    logic       cs_fall;
    logic       cs_rise;

    spi_sck_sync u_sync (
        .clk_i      (clk),
        .resetq_i   (resetq),
        .sck_i      (spi_sck),
        .csn_i      (spi_csn),
        .io_i       (spi_io_in),
        .io_o       (io_s),
        .sck_rise_o (sck_rise),
        .sck_fall_o (sck_fall),
        .cs_fall_o  (cs_fall),
        .cs_rise_o  (cs_rise)
    );

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [6:0]         cmd_q, cmd_d;
    logic [WADDR_W-1:0] addr_q, addr_d;
    logic [1:0]         out_q, out_d;
    logic               rstrb_q, rstrb_d;
    logic [WADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic               hold_vld_q, hold_vld_d;
    logic               pend_q, pend_d;
    logic [DATA_W-1:0]  cur_q, cur_d;
    logic               cur_vld_q, cur_vld_d;
    logic               underrun_q, underrun_d;
    logic [7:0]         cmd_next;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            out_q      <= '0;
            rstrb_q    <= 1'b0;
            waddr_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            pend_q     <= 1'b0;
            cur_q      <= '0;
            cur_vld_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            out_q      <= out_d;
            rstrb_q    <= rstrb_d;
            waddr_q    <= waddr_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            pend_q     <= pend_d;
            cur_q      <= cur_d;
            cur_vld_q  <= cur_vld_d;
            underrun_q <= underrun_d;
        end
    end

    assign cmd_next = {cmd_q, io_s[0]};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        out_d      = out_q;
        rstrb_d    = 1'b0;
        waddr_d    = waddr_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        pend_d     = pend_q;
        cur_d      = cur_q;
        cur_vld_d  = cur_vld_q;
        underrun_d = 1'b0;

        // Read data is valid from the cycle after the strobe once rbusy is low.
        if (pend_q && !rstrb_q && !mem_rbusy) begin
            hold_d     = mem_rdata;
            hold_vld_d = 1'b1;
            pend_d     = 1'b0;
        end

        case (state_q)
            ST_CMD: begin
                if (sck_rise) begin
                    cmd_d = cmd_next[6:0];
                    if (cnt_q == 8'd7) begin
                        cnt_d   = '0;
                        state_d = (cmd_next == CMD_DUAL_READ) ? ST_ADDR : ST_IGNORE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            ST_ADDR: begin
                if (sck_rise) begin
                    addr_d = {addr_q[WADDR_W-3:0], io_s};
                    if (32'(cnt_q) == ADDR_PAIRS - 1) begin
                        // The final pair carries addr[1:0], which is not needed.
                        cnt_d      = '0;
                        rstrb_d    = 1'b1;
                        waddr_d    = addr_q;
                        pend_d     = 1'b1;
                        hold_vld_d = 1'b0;
                        state_d    = (DUMMY_CYCLES == 0) ? ST_DATA : ST_DUMMY;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            ST_DUMMY: begin
                if (sck_rise) begin
                    if (32'(cnt_q) == DUMMY_CYCLES - 1) begin
                        cnt_d   = '0;
                        state_d = ST_DATA;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end

            ST_DATA: begin
                if (sck_fall) begin
`ifndef SPI_RESP_BURST_EN
                    if (cnt_q == 8'd16) begin
                        out_d   = '0;
                        state_d = ST_IGNORE;
                    end else
`endif
                    begin
                        if (cnt_q[3:0] == 4'd0) begin
                            if (hold_vld_d) begin
                                cur_d      = hold_d;
                                cur_vld_d  = 1'b1;
                                hold_vld_d = 1'b0;
                                out_d      = pair_sel(hold_d, 4'd0);
                            end else begin
                                cur_vld_d  = 1'b0;
                                out_d      = '0;
                                underrun_d = 1'b1;
                            end
`ifdef SPI_RESP_BURST_EN
                            rstrb_d = 1'b1;
                            waddr_d = waddr_q + 22'd1;
                            pend_d  = 1'b1;
`endif
                        end else begin
                            out_d = cur_vld_q ? pair_sel(cur_q, cnt_q[3:0]) : 2'b00;
                        end
`ifdef SPI_RESP_BURST_EN
                        cnt_d = {4'b0000, cnt_q[3:0] + 4'd1};
`else
                        cnt_d = cnt_q + 8'd1;
`endif
                    end
                end
            end

            default: ;
        endcase

        if (cs_rise) begin
            state_d    = ST_IDLE;
            out_d      = '0;
            rstrb_d    = 1'b0;
            pend_d     = 1'b0;
            hold_vld_d = 1'b0;
            cur_vld_d  = 1'b0;
            underrun_d = 1'b0;
        end else if (cs_fall) begin
            state_d    = ST_CMD;
            cnt_d      = '0;
            out_d      = '0;
            rstrb_d    = 1'b0;
            pend_d     = 1'b0;
            hold_vld_d = 1'b0;
            cur_vld_d  = 1'b0;
        end
    end

    assign spi_io_out       = out_q;
    assign spi_io_oe        = (state_q == ST_DATA) ? 2'b11 : 2'b00;
    assign mem_rstrb        = rstrb_q;
    assign mem_word_address = waddr_q;
    assign underrun         = underrun_q;

endmodule

// File: tb/tb_spi_dual_responder.sv
// Scoreboard bench for spi_dual_responder; honours SPI_RESP_BURST_EN when defined.
module tb_spi_dual_responder;

    localparam int DUMMY = 4;

    logic        clk = 1'b0;
    logic        resetq;
    logic        spi_sck;
    logic        spi_csn;
    logic [1:0]  spi_io_in;
    logic [1:0]  spi_io_out;
    logic [1:0]  spi_io_oe;
    logic        mem_rstrb;
    logic [21:0] mem_word_address;
    logic [31:0] mem_rdata;
    logic        mem_rbusy;
    logic        underrun;

    always #5 clk = ~clk;

    spi_dual_responder #(
        .DUMMY_CYCLES  (DUMMY),
        .CMD_DUAL_READ (8'hBB)
    ) dut (
        .clk              (clk),
        .resetq           (resetq),
        .spi_sck          (spi_sck),
        .spi_csn          (spi_csn),
        .spi_io_in        (spi_io_in),
        .spi_io_out       (spi_io_out),
        .spi_io_oe        (spi_io_oe),
        .mem_rstrb        (mem_rstrb),
        .mem_word_address (mem_word_address),
        .mem_rdata        (mem_rdata),
        .mem_rbusy        (mem_rbusy),
        .underrun         (underrun)
    );

    int          total = 0;
    int          bad   = 0;
    int          half  = 2;
    int          busy_delay = 0;
    int          busy_left  = 0;
    int          ur_cnt  = 0;
    int          ur_snap = 0;
    logic [21:0] rd_addr = '0;
    logic [21:0] strobe_log[$];
    logic [1:0]  exp_q[$];
    logic [1:0]  got_out[$];
    logic [1:0]  got_oe[$];

    function automatic logic [31:0] mem_word(input logic [21:0] a);
        if (a == 22'h4) return 32'h44332211;
        return {a[7:0] + 8'h3C, ~a[7:0], a[15:8] ^ 8'h5A, a[7:0] ^ 8'hC3};
    endfunction

    // Memory model: answers each strobe after busy_delay cycles of rbusy.
    always @(posedge clk) begin
        if (mem_rstrb) begin
            strobe_log.push_back(mem_word_address);
            rd_addr   <= mem_word_address;
            busy_left <= busy_delay;
            if (busy_delay == 0) begin
                mem_rbusy <= 1'b0;
                mem_rdata <= mem_word(mem_word_address);
            end else begin
                mem_rbusy <= 1'b1;
                mem_rdata <= 32'hDEADBEEF;
            end
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
            if (busy_left == 1) begin
                mem_rbusy <= 1'b0;
                mem_rdata <= mem_word(rd_addr);
            end
        end
        if (underrun) ur_cnt++;
    end

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 4; k++)
                exp_q.push_back(w[b*8 + 7 - 2*k -: 2]);
    endtask

    task automatic clocks(input int n, input logic [1:0] d, input bit rnd);
        for (int i = 0; i < n; i++) begin
            spi_io_in = rnd ? 2'($urandom_range(0, 3)) : d;
            repeat (half) @(negedge clk);
            spi_sck = 1'b1;
            repeat (half) @(negedge clk);
            got_out.push_back(spi_io_out);
            got_oe.push_back(spi_io_oe);
            ur_snap = ur_cnt;
            spi_sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        @(negedge clk);
        spi_csn = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (2) @(negedge clk);
        spi_csn = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_cmd(input logic [7:0] c);
        for (int i = 0; i < 8; i++) clocks(1, {1'b0, c[7-i]}, 1'b0);
    endtask

    task automatic send_addr(input logic [23:0] a, input int n);
        for (int i = 0; i < n; i++) clocks(1, a[23 - 2*i -: 2], 1'b0);
    endtask

    task automatic header(input logic [23:0] a);
        cs_low();
        send_cmd(8'hBB);
        send_addr(a, 12);
        got_out.delete();
        got_oe.delete();
        clocks(DUMMY, 2'b00, 1'b0);
        for (int i = 0; i < DUMMY; i++) begin
            total++;
            if (got_oe[i] !== 2'b00) begin
                bad++;
                $display("FAIL dummy_oe[%0d]: got %b want 00", i, got_oe[i]);
            end
        end
        got_out.delete();
        got_oe.delete();
    endtask

    task automatic test_reset();
        resetq = 1'b0; spi_csn = 1'b1; spi_sck = 1'b0; spi_io_in = '0;
        repeat (5) @(negedge clk);
        total += 5;
        if (spi_io_oe !== 2'b00)       begin bad++; $display("FAIL rst_oe: got %b want 00", spi_io_oe); end
        if (spi_io_out !== 2'b00)      begin bad++; $display("FAIL rst_out: got %b want 00", spi_io_out); end
        if (mem_rstrb !== 1'b0)        begin bad++; $display("FAIL rst_rstrb: got %b want 0", mem_rstrb); end
        if (mem_word_address !== '0)   begin bad++; $display("FAIL rst_waddr: got %h want 0", mem_word_address); end
        if (underrun !== 1'b0)         begin bad++; $display("FAIL rst_underrun: got %b want 0", underrun); end
        resetq = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (spi_io_oe !== 2'b00) begin bad++; $display("FAIL post_rst_oe: got %b want 00", spi_io_oe); end
    endtask

    task automatic check_data(input string name, input int n);
        logic [1:0] e;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            total++;
            if (got_out[i] !== e || got_oe[i] !== 2'b11) begin
                bad++;
                $display("FAIL %s pair %0d: got io=%b oe=%b want io=%b oe=11", name, i, got_out[i], got_oe[i], e);
            end
        end
    endtask

    task automatic test_dual_read();
        int ur0;
        busy_delay = 0; strobe_log.delete(); exp_q.delete(); ur0 = ur_cnt;
        push_word(32'h44332211);
        header(24'h000010);
        clocks(16, 2'b00, 1'b0);
        check_data("dual_read", 16);
        total += 2;
        if (strobe_log.size() < 1 || strobe_log[0] !== 22'h4) begin
            bad++; $display("FAIL dual_read_addr: got %h want 000004", strobe_log.size() ? strobe_log[0] : 22'h3FFFFF);
        end
        if (ur_snap - ur0 != 0) begin bad++; $display("FAIL dual_read_underrun: got %0d want 0", ur_snap - ur0); end
        repeat (4) @(negedge clk);
        total++;
`ifdef SPI_RESP_BURST_EN
        if (spi_io_oe !== 2'b11) begin bad++; $display("FAIL dual_read_burst_oe: got %b want 11", spi_io_oe); end
`else
        if (spi_io_oe !== 2'b00 || strobe_log.size() != 1) begin
            bad++; $display("FAIL dual_read_end: got oe=%b strobes=%0d want oe=00 strobes=1", spi_io_oe, strobe_log.size());
        end
`endif
        cs_high();
    endtask

    task automatic test_bad_cmd();
        strobe_log.delete();
        cs_low();
        send_cmd(8'h03);
        got_oe.delete(); got_out.delete();
        clocks(32, 2'b00, 1'b1);
        for (int i = 0; i < 32; i++) begin
            total++;
            if (got_oe[i] !== 2'b00) begin bad++; $display("FAIL bad_cmd_oe[%0d]: got %b want 00", i, got_oe[i]); end
        end
        total++;
        if (strobe_log.size() != 0) begin bad++; $display("FAIL bad_cmd_rstrb: got %0d want 0", strobe_log.size()); end
        cs_high();
    endtask

    task automatic test_abort();
        strobe_log.delete(); exp_q.delete();
        cs_low();
        send_cmd(8'hBB);
        send_addr(24'h000010, 6);
        @(negedge clk);
        spi_csn = 1'b1;
        repeat (20) @(negedge clk);
        total++;
        if (strobe_log.size() != 0) begin bad++; $display("FAIL abort_addr_rstrb: got %0d want 0", strobe_log.size()); end

        push_word(mem_word(22'h48));
        header(24'h000123);
        clocks(16, 2'b00, 1'b0);
        check_data("after_abort", 16);
        total++;
        if (strobe_log.size() < 1 || strobe_log[0] !== 22'h48) begin
            bad++; $display("FAIL after_abort_addr: got %h want 000048", strobe_log.size() ? strobe_log[0] : 22'h3FFFFF);
        end
        cs_high();

        exp_q.delete();
        push_word(mem_word(22'h80));
        header(24'h000200);
        clocks(8, 2'b00, 1'b0);
        check_data("abort_data", 8);
        exp_q.delete();
        @(negedge clk);
        spi_csn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (spi_io_oe !== 2'b00) begin bad++; $display("FAIL abort_data_oe: got %b want 00", spi_io_oe); end
        repeat (10) @(negedge clk);
    endtask

    task automatic test_underrun();
        int ur0;
        busy_delay = 200; strobe_log.delete(); exp_q.delete(); ur0 = ur_cnt;
        for (int i = 0; i < 16; i++) exp_q.push_back(2'b00);
        header(24'h000040);
        clocks(16, 2'b00, 1'b0);
        check_data("underrun", 16);
        total++;
        if (ur_snap - ur0 != 1) begin bad++; $display("FAIL underrun_pulses: got %0d want 1", ur_snap - ur0); end
        cs_high();
        repeat (250) @(negedge clk);
        busy_delay = 0;
    endtask

    task automatic test_burst();
        busy_delay = 0; strobe_log.delete(); exp_q.delete();
        header(24'hFFFFFC);
        push_word(mem_word(22'h3FFFFF));
`ifdef SPI_RESP_BURST_EN
        push_word(mem_word(22'h0));
        clocks(32, 2'b00, 1'b0);
        check_data("burst", 32);
        total++;
        if (strobe_log.size() < 2 || strobe_log[0] !== 22'h3FFFFF || strobe_log[1] !== 22'h0) begin
            bad++; $display("FAIL burst_addrs: got n=%0d want 3fffff then 000000", strobe_log.size());
        end
`else
        clocks(16, 2'b00, 1'b0);
        check_data("single", 16);
        got_out.delete(); got_oe.delete();
        clocks(4, 2'b00, 1'b0);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (got_oe[i] !== 2'b00) begin bad++; $display("FAIL single_end_oe[%0d]: got %b want 00", i, got_oe[i]); end
        end
        total++;
        if (strobe_log.size() != 1 || strobe_log[0] !== 22'h3FFFFF) begin
            bad++; $display("FAIL single_addr: got n=%0d want one strobe at 3fffff", strobe_log.size());
        end
`endif
        cs_high();
    endtask

    task automatic test_reset_mid_data();
        busy_delay = 0;
        header(24'h000010);
        clocks(4, 2'b00, 1'b0);
        total++;
        if (spi_io_oe !== 2'b11) begin bad++; $display("FAIL mid_data_oe: got %b want 11", spi_io_oe); end
        @(negedge clk);
        #3 resetq = 1'b0;
        #1;
        total += 4;
        if (spi_io_oe !== 2'b00)     begin bad++; $display("FAIL async_rst_oe: got %b want 00", spi_io_oe); end
        if (spi_io_out !== 2'b00)    begin bad++; $display("FAIL async_rst_out: got %b want 00", spi_io_out); end
        if (mem_word_address !== '0) begin bad++; $display("FAIL async_rst_waddr: got %h want 0", mem_word_address); end
        if (mem_rstrb !== 1'b0 || underrun !== 1'b0) begin
            bad++; $display("FAIL async_rst_pulses: got rstrb=%b underrun=%b want 0 0", mem_rstrb, underrun);
        end
        spi_csn = 1'b1;
        repeat (3) @(negedge clk);
        resetq = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        mem_rbusy = 1'b0;
        mem_rdata = '0;
        test_reset();
        test_dual_read();
        test_bad_cmd();
        test_abort();
        test_underrun();
        test_burst();
        test_reset_mid_data();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
